// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: types and constants shared by the hazard controller and
// its forwarding units.
//   state_e          : halt sequencer states {RUN, DRAIN, HALTED}
//   FWD_RF/WB/MEM    : EX operand forwarding select encodings
//   RESULT_SRC_LOAD  : result_src_e value that marks a load in EX
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// forward_unit: combinational EX-stage forwarding select for one operand.
//   rs_e_i          : source register of the operand in EX
//   rd_m_i, rd_w_i  : destination registers in MEM and WB
//   reg_write_m_i/w : register-write enables in MEM and WB
//   fwd_o           : FWD_MEM / FWD_WB / FWD_RF; MEM wins, x0 never forwarded
module forward_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (rs_e_i != 5'd0) begin
      if (reg_write_m_i && (rs_e_i == rd_m_i)) begin
        fwd_o = FWD_MEM;
      end else if (reg_write_w_i && (rs_e_i == rd_w_i)) begin
        fwd_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the five-stage pipeline.
// Drives stall/flush of the pipeline registers, EX forwarding selects, holds
// the pipeline during outstanding data-memory accesses, and sequences a debug
// halt (RUN -> DRAIN -> HALTED).
//   Inputs : clk, reset (sync, active high), decode/execute/mem/wb register
//            ids and write enables, result_src_e, pc_src_e, mem_access_m,
//            dmem_ready, halt_req
//   Outputs: stall_f/d/e/m, flush_d/e/w, forward_a_e/b_e, halted,
//            mem_timeout (sticky), stall_cnt/flush_cnt (PIPELINE_CTRL_PERF_EN)
// Optional feature macro: PIPELINE_CTRL_PERF_EN adds the performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic [4:0]  rd_m,
  input  logic [4:0]  rd_w,
  input  logic        reg_write_m,
  input  logic        reg_write_w,
  input  logic [1:0]  result_src_e,
  input  logic        pc_src_e,
  input  logic        mem_access_m,
  input  logic        dmem_ready,
  input  logic        halt_req,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
  output logic [1:0]  forward_a_e,
  output logic [1:0]  forward_b_e,
  output logic        halted,
`ifdef PIPELINE_CTRL_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        mem_timeout
);

  localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned WCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MEM_TIMEOUT);

  state_e         state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           timeout_q, timeout_d;

  logic       mem_stall;
  logic       lw_stall;
  logic [1:0] fwd_a, fwd_b;

  assign mem_stall = mem_access_m & ~dmem_ready;
  assign lw_stall  = (result_src_e == RESULT_SRC_LOAD) && (rd_e != 5'd0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));

  forward_unit u_fwd_a (
    .rs_e_i        (rs1_e),
    .rd_m_i        (rd_m),
    .rd_w_i        (rd_w),
    .reg_write_m_i (reg_write_m),
    .reg_write_w_i (reg_write_w),
    .fwd_o         (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs_e_i        (rs2_e),
    .rd_m_i        (rd_m),
    .rd_w_i        (rd_w),
    .reg_write_m_i (reg_write_m),
    .reg_write_w_i (reg_write_w),
    .fwd_o         (fwd_b)
  );

  // Combinational outputs are held at their reset values while reset is high.
  assign forward_a_e = reset ? FWD_RF : fwd_a;
  assign forward_b_e = reset ? FWD_RF : fwd_b;
  assign halted      = (state_q == HALTED);
  assign mem_timeout = timeout_q;

  // Stall/flush: a memory wait freezes everything up to MEM and overrides all
  // other hazards; otherwise the branch beats the load-use stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        stall_f = lw_stall & ~pc_src_e;
        stall_d = lw_stall & ~pc_src_e;
        flush_d = pc_src_e;
        flush_e = lw_stall | pc_src_e;
        if (state_q != RUN) begin
          flush_d = 1'b1;
          // While draining, a redirect must still reach the PC.
          stall_f = (state_q == HALTED) ? 1'b1 : ~pc_src_e;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;

    if (mem_stall) begin
      if (wait_cnt_q == WAIT_LIMIT) begin
        timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
      end
      if (wait_cnt_q == WAIT_LIMIT) begin
        wait_cnt_d = wait_cnt_q;
      end
    end

    unique case (state_q)
      RUN: begin
        drain_cnt_d = '0;
        if (halt_req && !mem_stall) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!halt_req) begin
          state_d     = RUN;
          drain_cnt_d = '0;
        end else if (!mem_stall) begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d     = HALTED;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + DCW'(1);
          end
        end
      end
      HALTED: begin
        if (!halt_req) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d     = RUN;
        drain_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_d) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_e) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  typedef struct packed {
    logic       reset;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_write_m, reg_write_w;
    logic [1:0] result_src_e;
    logic       pc_src_e, mem_access_m, dmem_ready, halt_req;
  } in_t;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}, fa, fb, halted, timeout
  typedef struct packed {
    logic [6:0] sf;
    logic [1:0] fa, fb;
    logic       halted, timeout;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0, rd_m = '0, rd_w = '0;
  logic reg_write_m = 1'b0, reg_write_w = 1'b0;
  logic [1:0] result_src_e = '0;
  logic pc_src_e = 1'b0, mem_access_m = 1'b0, dmem_ready = 1'b0, halt_req = 1'b0;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] forward_a_e, forward_b_e;
  logic halted, mem_timeout;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int fails  = 0;
  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(2), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e),
    .mem_access_m(mem_access_m), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .halted(halted),
`ifdef PIPELINE_CTRL_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mem_timeout(mem_timeout)
  );

  function automatic exp_t ex(input logic [6:0] sf, input logic [1:0] fa, input logic [1:0] fb,
                              input logic h, input logic to);
    exp_t e;
    e.sf = sf; e.fa = fa; e.fb = fb; e.halted = h; e.timeout = to;
    return e;
  endfunction

  task automatic step(input string nm, input in_t v, input exp_t e);
    @(posedge clk); #1;
    reset = v.reset; rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
    rd_e = v.rd_e; rd_m = v.rd_m; rd_w = v.rd_w;
    reg_write_m = v.reg_write_m; reg_write_w = v.reg_write_w;
    result_src_e = v.result_src_e; pc_src_e = v.pc_src_e;
    mem_access_m = v.mem_access_m; dmem_ready = v.dmem_ready; halt_req = v.halt_req;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one vector presented per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.sf = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
      a.fa = forward_a_e; a.fb = forward_b_e;
      a.halted = halted; a.timeout = mem_timeout;
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got sf=%b fa=%b fb=%b halted=%b to=%b, expected sf=%b fa=%b fb=%b halted=%b to=%b",
                 n, a.sf, a.fa, a.fb, a.halted, a.timeout, e.sf, e.fa, e.fb, e.halted, e.timeout);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 20000");
    $fatal(1);
  end

  initial begin
    in_t v;
    repeat (2) @(posedge clk);

    v = '0; step("reset_state", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0));
    v = '0; v.result_src_e = 2'b01; v.rd_e = 5'd5; v.rs1_d = 5'd5;
    step("load_use_rs1", v, ex(7'b1100010, 2'b00, 2'b00, 1'b0, 1'b0));
    v = '0; v.result_src_e = 2'b01; v.rd_e = 5'd5; v.rs1_d = 5'd3; v.rs2_d = 5'd5;
    step("load_use_rs2", v, ex(7'b1100010, 2'b00, 2'b00, 1'b0, 1'b0));
    v = '0; v.result_src_e = 2'b01; v.rd_e = 5'd0; v.rs1_d = 5'd0; v.rs2_d = 5'd0;
    step("load_use_x0", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0));
    v = '0; v.result_src_e = 2'b10; v.rd_e = 5'd5; v.rs1_d = 5'd5;
    step("no_load", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0));

    v = '0; v.rs1_e = 5'd7; v.rd_m = 5'd7; v.rd_w = 5'd7; v.reg_write_m = 1'b1; v.reg_write_w = 1'b1;
    step("fwd_mem_prio", v, ex(7'b0000000, 2'b10, 2'b00, 1'b0, 1'b0));
    v.reg_write_m = 1'b0;
    step("fwd_wb", v, ex(7'b0000000, 2'b01, 2'b00, 1'b0, 1'b0));
    v = '0; v.rs1_e = 5'd9; v.rs2_e = 5'd9; v.rd_m = 5'd9; v.rd_w = 5'd9; v.reg_write_m = 1'b1;
    step("fwd_both_mem", v, ex(7'b0000000, 2'b10, 2'b10, 1'b0, 1'b0));
    v = '0; v.rs1_e = 5'd0; v.rs2_e = 5'd0; v.rd_m = 5'd0; v.rd_w = 5'd0; v.reg_write_m = 1'b1; v.reg_write_w = 1'b1;
    step("fwd_x0", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0));
    v = '0; v.rs1_e = 5'd4; v.rs2_e = 5'd6; v.rd_m = 5'd4; v.rd_w = 5'd6; v.reg_write_w = 1'b1;
    step("fwd_none_a_wb_b", v, ex(7'b0000000, 2'b00, 2'b01, 1'b0, 1'b0));

    v = '0; v.pc_src_e = 1'b1;
    step("branch_only", v, ex(7'b0000110, 2'b00, 2'b00, 1'b0, 1'b0));
    v = '0; v.pc_src_e = 1'b1; v.result_src_e = 2'b01; v.rd_e = 5'd5; v.rs1_d = 5'd5;
    step("branch_vs_lw", v, ex(7'b0000110, 2'b00, 2'b00, 1'b0, 1'b0));

    // Memory wait with MEM_TIMEOUT=2: timeout visible from the 4th wait cycle.
    v = '0; v.pc_src_e = 1'b1; v.mem_access_m = 1'b1; v.dmem_ready = 1'b0;
    v.result_src_e = 2'b01; v.rd_e = 5'd5; v.rs1_d = 5'd5;
    step("mem_wait_1", v, ex(7'b1111001, 2'b00, 2'b00, 1'b0, 1'b0));
    step("mem_wait_2", v, ex(7'b1111001, 2'b00, 2'b00, 1'b0, 1'b0));
    step("mem_wait_3", v, ex(7'b1111001, 2'b00, 2'b00, 1'b0, 1'b0));
    step("mem_wait_4", v, ex(7'b1111001, 2'b00, 2'b00, 1'b0, 1'b1));
    v = '0; v.mem_access_m = 1'b1; v.dmem_ready = 1'b1;
    step("mem_done", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1));
    v = '0;
    step("timeout_sticky", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1));

    // Plain halt: 4 DRAIN cycles, halted after the 5th edge.
    v = '0; v.halt_req = 1'b1;
    step("halt_req_run", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++)
      step("drain", v, ex(7'b1000100, 2'b00, 2'b00, 1'b0, 1'b1));
    step("halted", v, ex(7'b1000100, 2'b00, 2'b00, 1'b1, 1'b1));
    v.halt_req = 1'b0;
    step("halted_release_cycle", v, ex(7'b1000100, 2'b00, 2'b00, 1'b1, 1'b1));
    step("released", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1));

    // Halt deferred by a memory wait, redirect and memory stall inside DRAIN.
    v = '0; v.halt_req = 1'b1; v.mem_access_m = 1'b1;
    step("halt_blocked_by_mem", v, ex(7'b1111001, 2'b00, 2'b00, 1'b0, 1'b1));
    v = '0; v.halt_req = 1'b1;
    step("halt_enter", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1));
    v.pc_src_e = 1'b1;
    step("drain_redirect", v, ex(7'b0000110, 2'b00, 2'b00, 1'b0, 1'b1));
    v = '0; v.halt_req = 1'b1; v.mem_access_m = 1'b1;
    step("drain_mem_stall", v, ex(7'b1111001, 2'b00, 2'b00, 1'b0, 1'b1));
    v = '0; v.halt_req = 1'b1;
    for (int i = 0; i < 3; i++)
      step("drain_ext", v, ex(7'b1000100, 2'b00, 2'b00, 1'b0, 1'b1));
    v.halt_req = 1'b0;
    step("halted_ext", v, ex(7'b1000100, 2'b00, 2'b00, 1'b1, 1'b1));
    step("released_ext", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1));

    // halt_req dropped mid-DRAIN returns to RUN.
    v = '0; v.halt_req = 1'b1;
    step("abort_enter", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1));
    v.halt_req = 1'b0;
    step("abort_drain", v, ex(7'b1000100, 2'b00, 2'b00, 1'b0, 1'b1));
    step("abort_run", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1));

    // Reset mid-DRAIN.
    v = '0; v.halt_req = 1'b1;
    step("rst_enter", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1));
    step("rst_drain", v, ex(7'b1000100, 2'b00, 2'b00, 1'b0, 1'b1));
    v.reset = 1'b1; v.rs1_e = 5'd3; v.rd_m = 5'd3; v.reg_write_m = 1'b1;
    step("rst_asserted", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1));
    v = '0;
    step("rst_after", v, ex(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0));
    v = '0; v.result_src_e = 2'b01; v.rd_e = 5'd8; v.rs2_d = 5'd8;
    step("run_after_rst", v, ex(7'b1100010, 2'b00, 2'b00, 1'b0, 1'b0));

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain_queue: %0d vectors unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage RISC-V pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also produces EX-stage operand forwarding selects and holds the pipeline while a data-memory access is outstanding. It sequences a debug halt that drains the pipeline before stopping instruction fetch.

## Interface
Parameters:
- MEM_TIMEOUT, 16: number of consecutive memory-wait cycles tolerated before `mem_timeout` is raised.
- DRAIN_CYCLES, 4: number of un-stalled cycles spent in DRAIN.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rs1_d, rs2_d  in  5  source registers of the instruction in decode.
- rs1_e, rs2_e, rd_e  in  5  source and destination registers in execute.
- rd_m, rd_w  in  5  destination registers in memory and writeback.
- reg_write_m, reg_write_w  in  1  register-write enables in MEM and WB.
- result_src_e  in  2  result source in EX; the value `RESULT_SRC_LOAD` (2'b01) marks a load.
- pc_src_e  in  1  taken branch or jump resolved in EX.
- mem_access_m  in  1  load or store present in MEM.
- dmem_ready  in  1  data memory has completed the access this cycle.
- halt_req  in  1  debug halt request, level-sensitive.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- flush_d, flush_e, flush_w  out  1  clear IF/ID, ID/EX and MEM/WB control to a bubble.
- forward_a_e, forward_b_e  out  2  forwarding select: 00 = register file, 01 = WB result, 10 = MEM result.
- halted  out  1  pipeline is drained and stopped.
- mem_timeout  out  1  sticky error flag; cleared only by reset.
- stall_cnt, flush_cnt  out  32  performance counters; present only with `PIPELINE_CTRL_PERF_EN`.

## Operation
Signal definitions:
- mem_stall = mem_access_m & ~dmem_ready.
- lw_stall = (result_src_e == 2'b01) & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d).

Forwarding (computed per operand):
- If rsX_e != 0, rsX_e == rd_m and reg_write_m → 10.
- Else if rsX_e != 0, rsX_e == rd_w and reg_write_w → 01.
- Else → 00.
- MEM takes priority over WB.
- x0 is never forwarded.

Memory wait (highest priority):
- When mem_stall: stall_f, stall_d, stall_e and stall_m = 1, and flush_w = 1.
- flush_d and flush_e are forced to 0 during mem_stall.
- lw_stall and pc_src_e are ignored during mem_stall; they are re-evaluated once the stall ends, because E is held.

Normal hazards (when there is no mem_stall):
- stall_f = stall_d = lw_stall.
- flush_d = pc_src_e.
- flush_e = lw_stall | pc_src_e.
- When pc_src_e and lw_stall are both asserted, the branch wins: stall_f = stall_d = 0.

FSM states: RUN, DRAIN, HALTED.

- RUN:
  - Normal hazard logic applies.
  - halt_req & ~mem_stall → DRAIN.
- DRAIN:
  - stall_f = 1 and flush_d = 1 in addition to the normal hazard terms.
  - If pc_src_e is asserted, stall_f = 0 for that cycle so the PC captures the redirect target.
  - The drain counter increments on each cycle without mem_stall.
  - When the counter reaches DRAIN_CYCLES-1 and there is no mem_stall → HALTED.
  - If halt_req drops → RUN and the counter clears.
- HALTED:
  - stall_f = 1, flush_d = 1, halted = 1.
  - When halt_req drops → RUN.

Wait counter:
- Increments on every mem_stall cycle and clears on any cycle without mem_stall.
- If mem_stall is asserted while the counter == MEM_TIMEOUT, mem_timeout is set; it stays set until reset.
- The counter saturates at MEM_TIMEOUT.

Reset values:
- All stall and flush outputs 0, forward selects 00, halted 0, mem_timeout 0.
- State RUN; all counters 0.
- A reset asserted mid-DRAIN or mid-wait aborts the operation immediately.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and state, valid in the same cycle. The pipeline registers act on them at the next edge.
- State and counters update on the rising edge; halted is a registered state decode.
- Latency from halt_req to halted is DRAIN_CYCLES+1 edges, extended by any mem_stall cycles.
- Release from halt: halted = 0 one edge after halt_req drops.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined:
  - stall_cnt increments on every cycle with stall_d = 1.
  - flush_cnt increments on every cycle with flush_e = 1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Package `pipeline_ctrl_pkg` holds:
  - the state enum {RUN, DRAIN, HALTED};
  - the forwarding encodings FWD_RF, FWD_WB, FWD_MEM;
  - RESULT_SRC_LOAD.
- Sub-module `forward_unit`: combinational, instantiated once per operand.

## Test plan
- Load-use: result_src_e=01, rd_e=5, rs1_d=5 → stall_f=stall_d=flush_e=1 for one cycle. The same stimulus with rd_e=0 → all outputs 0.
- Forward priority: rs1_e=7, rd_m=rd_w=7, reg_write_m=reg_write_w=1 → forward_a_e=10. With reg_write_m=0 → 01. With rs2_e=0, rd_m=0 → forward_b_e=00.
- Branch: pc_src_e=1 together with lw_stall → flush_d=flush_e=1 and stall_f=0.
- Memory wait, MEM_TIMEOUT=2, mem_access_m=1, dmem_ready=0 for 4 cycles with pc_src_e=1:
  - stall_f/d/e/m=1 and flush_w=1 every cycle;
  - flush_e=0 throughout;
  - mem_timeout=1 from the 4th cycle onward and held after dmem_ready=1.
- Halt, DRAIN_CYCLES=4, halt_req=1: DRAIN for 4 cycles, halted=1 after the 5th edge. Dropping halt_req → halted=0 next edge.
- Reset asserted during DRAIN → state RUN, all outputs 0 on the next cycle.
